double_mat_stream_ctrl: RTL and testbench
=========================================

Name: double_mat_stream_ctrl

Overview:
- Initiator and stream front-end for the parallel element-wise matrix arithmetic blocks (matrix subtract, with the same start/f protocol).
- Accepts operand pairs serially over a valid/ready stream and fills the operand matrices row-major.
- Resets the arithmetic block, then holds its start high until its done flag f rises, and captures the result matrix.
- Streams the result back out serially, row-major, with a last marker.

Parameters:
- SIZE_A, 8, matrix rows.
- SIZE_B, 8, matrix columns.
- MAX_WAIT, 64, cycles in RUN without f before a timeout is flagged.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid & in_ready.
- in_a  in  double(64)  element of matrix A.
- in_b  in  double(64)  element of matrix B.
- mat_a  out  double[SIZE_A][SIZE_B]  operand A to the arithmetic block.
- mat_b  out  double[SIZE_A][SIZE_B]  operand B to the arithmetic block.
- op_clr  out  1  reset pulse to the arithmetic block's rst.
- op_start  out  1  start/clock-enable to the arithmetic block.
- op_f  in  1  done flag from the arithmetic block.
- op_result  in  double[SIZE_A][SIZE_B]  result matrix from the arithmetic block.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result beat.
- out_data  out  double(64)  result element.
- out_last  out  1  high on the final element (index N-1).
- busy  out  1  high in any state other than LOAD.
- timeout  out  1  sticky; set when the RUN wait expired.

Behaviour:
- N = SIZE_A*SIZE_B; idx is $clog2(N) bits (minimum 1). Element k maps to row k/SIZE_B, column k%SIZE_B.
- Reset values:
  - State = LOAD, idx = 0, wait counter = 0.
  - All outputs 0: in_ready = 0 during reset; op_clr, op_start, out_valid, out_last, busy and timeout = 0.
  - mat_a, mat_b and the result buffer are cleared to 0.
- LOAD:
  - in_ready = 1.
  - On a handshake, write in_a/in_b to mat_a[idx]/mat_b[idx] and increment idx.
  - On the handshake at idx = N-1, idx wraps to 0 and the state moves to CLR.
  - No beat is accepted in any other state.
- CLR (exactly 1 cycle):
  - op_clr = 1 (registered), which clears the arithmetic block's internal count and f.
  - Wait counter cleared; next state RUN.
- RUN:
  - op_start = 1, held continuously; mat_a/mat_b stay stable.
  - op_f is sampled only in RUN. On the first clk edge with op_f = 1, op_result is captured into the result buffer, op_start drops on the following cycle, and the state moves to DRAIN.
  - If the wait counter reaches MAX_WAIT with op_f still 0: timeout <= 1, the buffer is captured anyway, and the state moves to DRAIN.
  - The wait counter increments every RUN cycle and saturates.
- DRAIN:
  - out_valid = 1, out_data = result[idx], out_last = (idx == N-1).
  - out_data is held stable while out_valid & !out_ready.
  - On a handshake idx increments; the handshake at idx = N-1 wraps idx to 0 and returns to LOAD.
- Latency:
  - With the 7-cycle arithmetic block, op_f is first seen 8 cycles after op_start rises.
  - The first result beat is valid on the cycle after capture.
- timeout clears only on rst; it does not block further operations.
- Reset mid-operation: every state returns to LOAD with idx = 0, and partial matrices are discarded (zeroed).
- Since op_clr drives an asynchronous reset, it comes directly from a flop.

Test Plan:
- Load 64 pairs with A[k] = k+1.0 and B[k] = 0.5, using an arithmetic-block model with a 7-cycle latency -> op_clr pulses exactly 1 cycle, op_start is held until op_f, and 64 out beats of k+0.5 arrive in row-major order with out_last only on beat 63.
- Run two back-to-back operations -> op_clr re-pulses, and the second result uses only the second operand set (no immediate stale f).
- Randomly deassert in_valid and out_ready (~50%) -> no beat is lost or duplicated, and out_data stays stable while stalled.
- Hold op_f = 0 forever -> timeout = 1 after 64 RUN cycles, 64 beats are still drained, and the state returns to LOAD.
- Assert rst after 30 loaded beats, then load a full new set -> only the new set is used, and busy = 0 with in_ready = 1 after reset.
- Use SIZE_A = 1 and SIZE_B = 1 -> a single beat per phase, and out_last = 1 on the only beat.

Source files
------------

// File: rtl/double_mat_stream_ctrl_if.sv
// Stream and arithmetic-block bundle for double_mat_stream_ctrl.
// Doubles are carried as raw IEEE-754 bit patterns.
// Matrices are packed [row][col], so they flatten to row-major element order.
interface double_mat_stream_ctrl_if #(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8
);
  logic                                   in_valid;
  logic                                   in_ready;
  logic [63:0]                            in_a;
  logic [63:0]                            in_b;
  logic [SIZE_A-1:0][SIZE_B-1:0][63:0]    mat_a;
  logic [SIZE_A-1:0][SIZE_B-1:0][63:0]    mat_b;
  logic                                   op_clr;
  logic                                   op_start;
  logic                                   op_f;
  logic [SIZE_A-1:0][SIZE_B-1:0][63:0]    op_result;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [63:0]                            out_data;
  logic                                   out_last;
  logic                                   busy;
  logic                                   timeout;

  // Controller side.
  modport slave (
    input  in_valid, in_a, in_b, op_f, op_result, out_ready,
    output in_ready, mat_a, mat_b, op_clr, op_start,
           out_valid, out_data, out_last, busy, timeout
  );

  // Environment side: operand source, arithmetic block and result sink.
  modport master (
    output in_valid, in_a, in_b, op_f, op_result, out_ready,
    input  in_ready, mat_a, mat_b, op_clr, op_start,
           out_valid, out_data, out_last, busy, timeout
  );
endinterface

// File: rtl/double_mat_stream_ctrl.sv
// Front-end and initiator for the element-wise matrix arithmetic blocks.
// Loads operand pairs serially, runs the block, then streams the result out.
//
//   state | meaning
//   LOAD  | accept operand beats into mat_a/mat_b, row-major
//   CLR   | one-cycle registered op_clr pulse, wait counter cleared
//   RUN   | op_start held until op_f or the wait limit, then capture result
//   DRAIN | stream captured result out, out_last on the final element
module double_mat_stream_ctrl #(
  parameter int SIZE_A   = 8,
  parameter int SIZE_B   = 8,
  parameter int MAX_WAIT = 64
) (
  input logic                     clk,
  input logic                     rst,
  double_mat_stream_ctrl_if.slave bus
);

  localparam int N  = SIZE_A * SIZE_B;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  // RUN lasts at most MAX_WAIT cycles: the limit hits on the cycle whose
  // pre-increment count is MAX_WAIT-1.
  localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {LOAD, CLR, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic               timeout_q, timeout_d;
  logic               in_ready_q;
  logic               op_clr_q;
  logic [N-1:0][63:0] mat_a_q, mat_b_q, res_q, res_in;
  logic               in_fire, out_fire, capture;

  // Packed [row][col] and flat [k] share the same bit layout (k = row*SIZE_B + col).
  assign res_in   = bus.op_result;
  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = (state_q == DRAIN) & bus.out_ready;

  // Next-state, index and wait-counter decisions.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    capture   = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (in_fire) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = CLR;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      CLR: begin
        wait_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        if (wait_q != '1) wait_d = wait_q + 1'b1;
        if (bus.op_f) begin
          capture = 1'b1;
          state_d = DRAIN;
        end else if (wait_q >= WAIT_LIM) begin
          capture   = 1'b1;
          timeout_d = 1'b1;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State, operand/result storage and registered handshake/clear outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      idx_q      <= '0;
      wait_q     <= '0;
      timeout_q  <= 1'b0;
      in_ready_q <= 1'b0;
      op_clr_q   <= 1'b0;
      mat_a_q    <= '0;
      mat_b_q    <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      timeout_q  <= timeout_d;
      in_ready_q <= (state_d == LOAD);
      // op_clr feeds the block's async reset, so it must come straight from a flop.
      op_clr_q   <= (state_d == CLR);
      if (in_fire) begin
        mat_a_q[idx_q] <= bus.in_a;
        mat_b_q[idx_q] <= bus.in_b;
      end
      if (capture) res_q <= res_in;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mat_a     = mat_a_q;
  assign bus.mat_b     = mat_b_q;
  assign bus.op_clr    = op_clr_q;
  assign bus.op_start  = (state_q == RUN);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_data  = res_q[idx_q];
  assign bus.out_last  = (state_q == DRAIN) && (idx_q == LAST_IDX);
  assign bus.busy      = (state_q != LOAD);
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_double_mat_stream_ctrl.sv
// Bench for double_mat_stream_ctrl: 8x8 instance against a phase-level model,
// plus a directed 1x1 instance.
module tb_double_mat_stream_ctrl;

  localparam int N8     = 64;
  localparam int MAXW   = 64;
  localparam int P_LOAD = 0, P_CLR = 1, P_RUN = 2, P_DRAIN = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  double_mat_stream_ctrl_if #(.SIZE_A(8), .SIZE_B(8)) if8 ();
  double_mat_stream_ctrl_if #(.SIZE_A(1), .SIZE_B(1)) if1 ();

  double_mat_stream_ctrl #(.SIZE_A(8), .SIZE_B(8), .MAX_WAIT(MAXW)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  double_mat_stream_ctrl #(.SIZE_A(1), .SIZE_B(1), .MAX_WAIT(MAXW)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  function automatic logic [63:0] dsub(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) - $bitstoreal(b));
  endfunction

  function automatic logic [63:0] rnd_dbl();
    return $realtobits($itor($urandom_range(4000)) / 8.0 - 250.0);
  endfunction

  // Arithmetic block (subtract) with a 7-cycle latency; hang keeps f low forever.
  bit                  hang;
  logic [7:0]          am_cnt;
  logic [N8-1:0][63:0] am_a, am_b, am_res;
  assign am_a = if8.mat_a;
  assign am_b = if8.mat_b;

  always_comb begin
    am_res = '0;
    for (int k = 0; k < N8; k++) am_res[k[5:0]] = dsub(am_a[k[5:0]], am_b[k[5:0]]);
  end

  always @(posedge clk or posedge if8.op_clr or posedge rst) begin
    if (rst || if8.op_clr) begin
      am_cnt        <= '0;
      if8.op_f      <= 1'b0;
      if8.op_result <= '0;
    end else if (if8.op_start && !if8.op_f) begin
      if (am_cnt == 8'd7) begin
        if (!hang) begin
          if8.op_f      <= 1'b1;
          if8.op_result <= am_res;
        end
      end else begin
        am_cnt <= am_cnt + 8'd1;
      end
    end
  end

  // One-cycle block for the 1x1 instance.
  always @(posedge clk or posedge if1.op_clr or posedge rst) begin
    if (rst || if1.op_clr) begin
      if1.op_f      <= 1'b0;
      if1.op_result <= '0;
    end else if (if1.op_start) begin
      if1.op_f      <= 1'b1;
      if1.op_result <= dsub(if1.mat_a, if1.mat_b);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chkd(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    chkd(name, {63'd0, got}, {63'd0, exp});
  endtask

  task automatic chki(input string name, input int got, input int exp);
    chkd(name, 64'(got), 64'(exp));
  endtask

  // Model: phase of the operation plus queues of accepted operands and
  // pending expected results.
  int                  phase;
  logic [63:0]         la[$], lb[$], exq[$], got[$];
  int                  run_cnt, run_len, beats, last_pos, ops_done;
  bit                  exp_to, first_after_rst, prev_stall, hs_in;
  logic [63:0]         prev_data;
  logic [N8-1:0][63:0] flat_a, flat_b;

  // Stimulus controls.
  logic [63:0] src_a[$], src_b[$];
  int          src_ptr, in_pct, out_pct;
  bit          rst_drv;

  task automatic compare();
    bit e_rdy, e_busy, e_clr, e_start, e_ov, e_last, ok;
    if (rst) begin
      chk1("rst_in_ready", if8.in_ready, 1'b0);
      chk1("rst_busy", if8.busy, 1'b0);
      chk1("rst_op_clr", if8.op_clr, 1'b0);
      chk1("rst_op_start", if8.op_start, 1'b0);
      chk1("rst_out_valid", if8.out_valid, 1'b0);
      chk1("rst_out_last", if8.out_last, 1'b0);
      chk1("rst_timeout", if8.timeout, 1'b0);
      chkd("rst_out_data", if8.out_data, 64'd0);
      flat_a = if8.mat_a;
      flat_b = if8.mat_b;
      chki("rst_mat_ones", $countones(flat_a) + $countones(flat_b), 0);
      phase = P_LOAD;
      la.delete(); lb.delete(); exq.delete();
      exp_to = 1'b0; first_after_rst = 1'b1; prev_stall = 1'b0; hs_in = 1'b0;
      run_cnt = 0;
      return;
    end
    e_rdy   = (phase == P_LOAD) && !first_after_rst;
    e_busy  = (phase != P_LOAD);
    e_clr   = (phase == P_CLR);
    e_start = (phase == P_RUN);
    e_ov    = (phase == P_DRAIN);
    e_last  = e_ov && (exq.size() == 1);
    chk1("in_ready", if8.in_ready, e_rdy);
    chk1("busy", if8.busy, e_busy);
    chk1("op_clr", if8.op_clr, e_clr);
    chk1("op_start", if8.op_start, e_start);
    chk1("out_valid", if8.out_valid, e_ov);
    chk1("out_last", if8.out_last, e_last);
    chk1("timeout", if8.timeout, exp_to);
    if (e_ov) chkd("out_data", if8.out_data, exq[0]);
    if (prev_stall) chkd("stall_hold", if8.out_data, prev_data);
    if (phase == P_CLR) begin
      flat_a = if8.mat_a;
      flat_b = if8.mat_b;
      ok = 1'b1;
      for (int k = 0; k < N8; k++)
        if (flat_a[k[5:0]] !== la[k] || flat_b[k[5:0]] !== lb[k]) ok = 1'b0;
      chk1("operands_loaded", ok, 1'b1);
    end

    hs_in           = e_rdy && if8.in_valid;
    prev_stall      = e_ov && !if8.out_ready;
    prev_data       = if8.out_data;
    first_after_rst = 1'b0;
    case (phase)
      P_LOAD: if (hs_in) begin
        la.push_back(if8.in_a);
        lb.push_back(if8.in_b);
        if (la.size() == N8) phase = P_CLR;
      end
      P_CLR: begin
        run_cnt = 0;
        phase   = P_RUN;
      end
      P_RUN: begin
        run_cnt++;
        if (if8.op_f || run_cnt == MAXW) begin
          exq.delete();
          for (int k = 0; k < N8; k++) exq.push_back(if8.op_f ? dsub(la[k], lb[k]) : 64'd0);
          if (!if8.op_f) exp_to = 1'b1;
          run_len  = run_cnt;
          beats    = 0;
          last_pos = -1;
          got.delete();
          phase    = P_DRAIN;
        end
      end
      default: if (if8.out_ready) begin
        got.push_back(if8.out_data);
        if (if8.out_last) last_pos = beats;
        beats++;
        void'(exq.pop_front());
        if (exq.size() == 0) begin
          phase = P_LOAD;
          la.delete(); lb.delete();
          ops_done++;
        end
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst = rst_drv;
    if (hs_in) src_ptr++;
    if (src_ptr < src_a.size() && $urandom_range(99) < in_pct) begin
      if8.in_valid = 1'b1;
      if8.in_a     = src_a[src_ptr];
      if8.in_b     = src_b[src_ptr];
    end else begin
      // Junk beats outside LOAD must never be taken.
      if8.in_valid = (phase != P_LOAD) ? 1'($urandom_range(1)) : 1'b0;
      if8.in_a     = {$urandom, $urandom};
      if8.in_b     = {$urandom, $urandom};
    end
    if8.out_ready = ($urandom_range(99) < out_pct);
    @(negedge clk);
    compare();
  endtask

  task automatic fill_src(input bit directed);
    src_a.delete(); src_b.delete();
    src_ptr = 0;
    for (int k = 0; k < N8; k++) begin
      src_a.push_back(directed ? $realtobits(k + 1.0) : rnd_dbl());
      src_b.push_back(directed ? $realtobits(0.5) : rnd_dbl());
    end
  endtask

  task automatic run_op(input bit directed, input int ip, input int op);
    int target, budget;
    target  = ops_done + 1;
    in_pct  = ip;
    out_pct = op;
    fill_src(directed);
    budget  = 0;
    while (ops_done < target && budget < 3000) begin
      step();
      budget++;
    end
    if (ops_done < target) begin
      checks++;
      errors++;
      $display("FAIL op_complete: ops_done %0d required %0d within 3000 cycles", ops_done, target);
    end
    src_a.delete(); src_b.delete();
  endtask

  task automatic do_reset();
    rst_drv = 1'b1;
    src_a.delete(); src_b.delete();
    src_ptr = 0;
    repeat (3) step();
    rst_drv = 1'b0;
    step();
  endtask

  initial begin
    int guard;
    bit ok;
    rst = 1'b1; rst_drv = 1'b1; hang = 1'b0;
    in_pct = 100; out_pct = 100; src_ptr = 0; ops_done = 0;
    phase = P_LOAD; hs_in = 1'b0; prev_stall = 1'b0; exp_to = 1'b0;
    run_len = 0; beats = 0; last_pos = -1;
    if8.in_valid = 1'b0; if8.in_a = '0; if8.in_b = '0; if8.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.out_ready = 1'b0;
    do_reset();
    step();

    // Directed: A[k] = k+1.0, B[k] = 0.5 -> k+0.5, row-major.
    run_op(1'b1, 100, 100);
    chki("op1_run_len", run_len, 9);
    chki("op1_beats", beats, 64);
    chki("op1_last_pos", last_pos, 63);
    chkd("op1_beat0", got[0], $realtobits(0.5));
    chkd("op1_beat9", got[9], $realtobits(9.5));
    chkd("op1_beat63", got[63], $realtobits(63.5));
    ok = 1'b1;
    for (int k = 0; k < N8; k++) if (got[k] !== $realtobits(k + 0.5)) ok = 1'b0;
    chk1("op1_all_beats", ok, 1'b1);

    // Back-to-back: a stale f would make the run length 1.
    run_op(1'b0, 100, 100);
    chki("op2_run_len", run_len, 9);
    chki("op2_beats", beats, 64);

    // Stalls on both sides.
    repeat (3) begin
      run_op(1'b0, 50, 50);
      chki("stall_op_beats", beats, 64);
      chki("stall_op_last_pos", last_pos, 63);
    end

    // Block never finishes: timeout after MAX_WAIT RUN cycles, zeros drained.
    hang = 1'b1;
    run_op(1'b0, 70, 60);
    hang = 1'b0;
    chki("to_run_len", run_len, 64);
    chki("to_beats", beats, 64);
    chk1("to_flag", if8.timeout, 1'b1);
    chkd("to_beat0", got[0], 64'd0);

    // Timeout is sticky but does not block the next operation.
    run_op(1'b0, 100, 100);
    chki("after_to_run_len", run_len, 9);
    chk1("after_to_flag", if8.timeout, 1'b1);

    // Reset after 30 loaded beats, then a complete new set.
    in_pct = 100;
    fill_src(1'b0);
    guard = 0;
    while (la.size() < 30 && guard < 500) begin
      step();
      guard++;
    end
    chki("mid_load_count", la.size(), 30);
    do_reset();
    step();
    chk1("post_rst_in_ready", if8.in_ready, 1'b1);
    chk1("post_rst_busy", if8.busy, 1'b0);
    chk1("post_rst_timeout", if8.timeout, 1'b0);
    run_op(1'b0, 80, 80);
    chki("post_rst_run_len", run_len, 9);
    chki("post_rst_beats", beats, 64);

    // 1x1 instance: one beat per phase, out_last on the only beat.
    chk1("s1_in_ready", if1.in_ready, 1'b1);
    if1.in_valid = 1'b1;
    if1.in_a     = $realtobits(3.0);
    if1.in_b     = $realtobits(1.25);
    step();
    if1.in_valid = 1'b0;
    chk1("s1_op_clr", if1.op_clr, 1'b1);
    chk1("s1_busy", if1.busy, 1'b1);
    chk1("s1_in_ready_clr", if1.in_ready, 1'b0);
    guard = 0;
    while (!if1.out_valid && guard < 20) begin
      step();
      guard++;
    end
    chk1("s1_out_valid", if1.out_valid, 1'b1);
    chkd("s1_out_data", if1.out_data, $realtobits(1.75));
    chk1("s1_out_last", if1.out_last, 1'b1);
    chkd("s1_mat_a", if1.mat_a, $realtobits(3.0));
    step();
    chkd("s1_stall_data", if1.out_data, $realtobits(1.75));
    if1.out_ready = 1'b1;
    step();
    if1.out_ready = 1'b0;
    chk1("s1_drained", if1.out_valid, 1'b0);
    chk1("s1_idle", if1.busy, 1'b0);
    step();
    chk1("s1_reload_ready", if1.in_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
